// File: rtl/fifo_read_stream.sv
// Read-side stream adapter for async_fifo: issues reads, absorbs the one-cycle
// read latency and presents words on a valid/ready stream through an elastic buffer.
module fifo_read_stream #(
   parameter int BITS  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     p_fifo_read_en,
   input  logic [BITS-1:0]          p_fifo_read_data,
   input  logic                     p_fifo_read_empty,
   output logic                     p_out_valid,
   input  logic                     p_out_ready,
   output logic [BITS-1:0]          p_out_data,
   output logic [$clog2(DEPTH):0]   p_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

   logic [BITS-1:0] buf_r [DEPTH];
   logic [AW-1:0]   wptr_r;
   logic [AW-1:0]   rptr_r;
   logic [CW-1:0]   count_r;
   logic            inflight_r;

   logic [CW:0]     committed_s;
   logic            read_en_s;
   logic            valid_s;
   logic            push_s;
   logic            pop_s;

   // Issue decision uses only registered occupancy so p_out_ready never reaches read-enable
   always_comb begin
      committed_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
      valid_s     = (count_r != {CW{1'b0}});
      push_s      = inflight_r;
      pop_s       = valid_s && p_out_ready;
      if (!p_fifo_read_empty && (committed_s < DEPTH_X)) begin
         read_en_s = 1'b1;
      end else begin
         read_en_s = 1'b0;
      end
   end

   // Buffer storage, pointers, occupancy and in-flight tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_r[i] <= {BITS{1'b0}};
         end
         wptr_r     <= {AW{1'b0}};
         rptr_r     <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= read_en_s;
         // Space for this word was reserved when the read was issued
         if (push_s) begin
            buf_r[wptr_r] <= p_fifo_read_data;
            wptr_r        <= wptr_r + AW'(1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign p_fifo_read_en = read_en_s;
   assign p_out_valid    = valid_s;
   assign p_out_data     = buf_r[rptr_r];
   assign p_level        = count_r;

   fifo_read_stream_chk #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .count    (count_r),
      .inflight (inflight_r),
      .push     (push_s),
      .valid    (valid_s),
      .ready    (p_out_ready),
      .data     (p_out_data)
   );

endmodule

// Occupancy and stream-stability properties for fifo_read_stream.
module fifo_read_stream_chk #(
   parameter int BITS  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [$clog2(DEPTH):0]   count,
   input  logic                     inflight,
   input  logic                     push,
   input  logic                     valid,
   input  logic                     ready,
   input  logic [BITS-1:0]          data
);

   localparam int CW = $clog2(DEPTH) + 1;

   a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
      (({1'b0, count} + {{CW{1'b0}}, inflight}) <= (CW + 1)'(DEPTH)));

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count == CW'(DEPTH))));

   a_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (valid && !ready) |=> (valid && $stable(data)));

endmodule
